// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges the core's fetch and load/store ports onto one
// shared memory port, one transaction in flight, variable memory latency.
//
// Ports
//   clk, resetn                       clock, async active-low reset
//   inst_req/addr -> inst_rdata/ok    fetch side, ok is a 1-cycle pulse
//   data_req/wr/wstrb/addr/wdata      load/store side
//   data_rdata/data_data_ok           load data and 1-cycle completion
//   mem_req/wr/wstrb/addr/wdata       shared port command (held to ready)
//   mem_ready, mem_rvalid, mem_rdata  shared port handshake and response
//   mem_timeout                       sticky, set on a forced completion
module cpu_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DATA_PRIO = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_data_ok,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_data_ok,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_timeout
);
    localparam int SW    = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    logic               r_owner;     // 1 = data side owns the transaction
    logic               r_last_data; // owner of the previous grant
    logic               r_mem_req;
    logic               r_wr;
    logic [SW-1:0]      r_wstrb;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_inst_rdata;
    logic [DATA_W-1:0]  r_data_rdata;
    logic               r_inst_ok;
    logic               r_data_ok;
    logic               r_timeout;

    logic               w_pick_data;
    logic               w_expire;

    // Data wins when it is alone, when it has fixed priority, or when
    // round-robin says the previous grant went to the fetch side.
    assign w_pick_data = data_req &&
        (!inst_req || (DATA_PRIO != 0) || !r_last_data);

    assign w_expire = (TIMEOUT != 0) &&
        (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            // First tie under round-robin goes to the fetch side.
            r_last_data  <= 1'b1;
            r_mem_req    <= 1'b0;
            r_wr         <= 1'b0;
            r_wstrb      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_inst_ok    <= 1'b0;
            r_data_ok    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (inst_req || data_req) begin
                        r_owner     <= w_pick_data;
                        r_last_data <= w_pick_data;
                        r_mem_req   <= 1'b1;
                        r_state     <= S_REQ;
                        if (w_pick_data) begin
                            r_wr    <= data_wr;
                            // Reads never drive strobes onto the port.
                            r_wstrb <= data_wr ? data_wstrb : '0;
                            r_addr  <= data_addr;
                            r_wdata <= data_wdata;
                        end else begin
                            r_wr    <= 1'b0;
                            r_wstrb <= '0;
                            r_addr  <= inst_addr;
                            r_wdata <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid || w_expire) begin
                        // Stores keep the previous load data; a forced
                        // completion returns zero to the reader.
                        if (!r_wr) begin
                            if (r_owner) begin
                                r_data_rdata <= mem_rvalid ? mem_rdata : '0;
                            end else begin
                                r_inst_rdata <= mem_rvalid ? mem_rdata : '0;
                            end
                        end
                        if (!mem_rvalid) begin
                            r_timeout <= 1'b1;
                        end
                        r_inst_ok <= !r_owner;
                        r_data_ok <= r_owner;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_inst_ok <= 1'b0;
                    r_data_ok <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign inst_rdata   = r_inst_rdata;
    assign inst_data_ok = r_inst_ok;
    assign data_rdata   = r_data_rdata;
    assign data_data_ok = r_data_ok;
    assign mem_req      = r_mem_req;
    assign mem_wr       = r_wr;
    assign mem_wstrb    = r_wstrb;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_timeout  = r_timeout;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: scoreboard bench for cpu_mem_arbiter.
// dut: fixed data priority, TIMEOUT=8; dut_rr: round-robin variant.
`timescale 1ns/1ps
module tb_cpu_mem_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        inst_req = 0, data_req = 0, data_wr = 0;
    logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0;
    logic [3:0]  data_wstrb = 0;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic        inst_data_ok, data_data_ok, mem_req, mem_wr, mem_timeout;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 0, mem_rvalid = 0;
    logic [31:0] mem_rdata = 0;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_timeout(mem_timeout)
    );

    logic        rr_inst_req = 0, rr_data_req = 0;
    logic        rr_data_wr = 0;
    logic [3:0]  rr_data_wstrb = 0;
    logic [31:0] rr_inst_addr = 32'h0000_0100, rr_data_addr = 32'h0000_0200;
    logic [31:0] rr_data_wdata = 0;
    logic        rr_mem_ready = 1, rr_mem_rvalid = 1;
    logic [31:0] rr_mem_rdata = 32'h5A5A_0000;
    logic [31:0] rr_inst_rdata, rr_data_rdata, rr_mem_addr, rr_mem_wdata;
    logic        rr_inst_ok, rr_data_ok, rr_mem_req, rr_mem_wr, rr_mem_timeout;
    logic [3:0]  rr_mem_wstrb;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(0), .TIMEOUT(8)) dut_rr (
        .clk(clk), .resetn(resetn),
        .inst_req(rr_inst_req), .inst_addr(rr_inst_addr),
        .inst_rdata(rr_inst_rdata), .inst_data_ok(rr_inst_ok),
        .data_req(rr_data_req), .data_wr(rr_data_wr), .data_wstrb(rr_data_wstrb),
        .data_addr(rr_data_addr), .data_wdata(rr_data_wdata),
        .data_rdata(rr_data_rdata), .data_data_ok(rr_data_ok),
        .mem_req(rr_mem_req), .mem_wr(rr_mem_wr), .mem_wstrb(rr_mem_wstrb),
        .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
        .mem_ready(rr_mem_ready), .mem_rvalid(rr_mem_rvalid),
        .mem_rdata(rr_mem_rdata), .mem_timeout(rr_mem_timeout)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_t;
    typedef struct {
        logic        side;
        logic [31:0] rdata;
    } resp_t;

    mem_t        exp_mem[$];
    resp_t       exp_resp[$];
    logic [31:0] rd_q[$];
    logic        rr_q[$];

    int cfg_ready_wait = 0;
    int cfg_rv_wait = 0;
    bit cfg_no_rv = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic mem_t mk_mem(input logic [31:0] a, input logic w,
                                    input logic [3:0] s, input logic [31:0] d);
        mem_t m;
        m.addr = a; m.wr = w; m.wstrb = s; m.wdata = d;
        return m;
    endfunction

    function automatic resp_t mk_resp(input logic s, input logic [31:0] d);
        resp_t r;
        r.side = s; r.rdata = d;
        return r;
    endfunction

    // Memory model for the main instance.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && resetn) begin
                repeat (cfg_ready_wait) @(negedge clk);
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
                repeat (cfg_rv_wait) @(negedge clk);
                if (!cfg_no_rv) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
                    @(negedge clk);
                    mem_rvalid = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        mem_t  e;
        resp_t r;
        #1;
        if (resetn) begin
            if (mem_req) begin
                if (exp_mem.size() == 0) begin
                    chk("unexpected_mem_req", 32'(mem_req), 32'd0);
                end else begin
                    e = exp_mem[0];
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_wr", 32'(mem_wr), 32'(e.wr));
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
                    if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
                    if (mem_ready) void'(exp_mem.pop_front());
                end
            end
            if (inst_data_ok && data_data_ok)
                chk("ok_overlap", 32'd1, 32'd0);
            if (inst_data_ok || data_data_ok) begin
                if (exp_resp.size() == 0) begin
                    chk("unexpected_ok", 32'd1, 32'd0);
                end else begin
                    r = exp_resp.pop_front();
                    chk("ok_side", 32'(data_data_ok), 32'(r.side));
                    chk("rdata", r.side ? data_rdata : inst_rdata, r.rdata);
                end
            end
        end
    end

    // Scoreboard monitor for the round-robin instance.
    always @(negedge clk) begin
        logic s;
        #1;
        if (resetn && (rr_inst_ok || rr_data_ok)) begin
            if (rr_inst_ok && rr_data_ok) chk("rr_overlap", 32'd1, 32'd0);
            if (rr_q.size() == 0) begin
                chk("rr_unexpected_ok", 32'd1, 32'd0);
            end else begin
                s = rr_q.pop_front();
                chk("rr_grant_side", 32'(rr_data_ok), 32'(s));
            end
        end
    end

    task automatic wait_ok(input bit side, input int maxc);
        bit seen = 0;
        for (int n = 0; n < maxc && !seen; n++) begin
            @(negedge clk);
            #2;
            seen = side ? data_data_ok : inst_data_ok;
        end
        if (!seen) chk(side ? "data_ok_wait" : "inst_ok_wait", 32'd0, 32'd1);
    endtask

    task automatic wait_mem_req(input int maxc);
        bit seen = 0;
        for (int n = 0; n < maxc && !seen; n++) begin
            @(negedge clk);
            #2;
            seen = mem_req;
        end
        if (!seen) chk("mem_req_wait", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int hold;
        int cnt;
        bit done;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        chk("rst_rdata", inst_rdata | data_rdata, 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single fetch at minimum latency
        exp_mem.push_back(mk_mem(32'hBFC0_0000, 0, 4'h0, 0));
        exp_resp.push_back(mk_resp(0, 32'h3C1D_0001));
        rd_q.push_back(32'h3C1D_0001);
        inst_addr = 32'hBFC0_0000;
        inst_req = 1'b1;
        @(negedge clk); #2;
        chk("t1_req_n1", 32'(mem_req), 32'd1);
        chk("t1_addr_n1", mem_addr, 32'hBFC0_0000);
        @(negedge clk);
        @(negedge clk); #2;
        chk("t1_ok_n3", 32'(inst_data_ok), 32'd1);
        chk("t1_rdata_n3", inst_rdata, 32'h3C1D_0001);
        inst_req = 1'b0;
        repeat (2) @(negedge clk);

        // 2: simultaneous requests, data first; load strobes forced to 0
        exp_mem.push_back(mk_mem(32'h8000_1000, 0, 4'h0, 0));
        exp_mem.push_back(mk_mem(32'hBFC0_0004, 0, 4'h0, 0));
        exp_resp.push_back(mk_resp(1, 32'h1111_2222));
        exp_resp.push_back(mk_resp(0, 32'h3333_4444));
        rd_q.push_back(32'h1111_2222);
        rd_q.push_back(32'h3333_4444);
        data_addr = 32'h8000_1000; data_wr = 0; data_wstrb = 4'hF;
        inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; inst_req = 1'b1;
        wait_ok(1, 20);
        data_req = 1'b0;
        @(negedge clk); #2;
        chk("t2_idle_gap", 32'(mem_req), 32'd0);
        @(negedge clk); #2;
        chk("t2_fetch_req", 32'(mem_req), 32'd1);
        chk("t2_fetch_addr", mem_addr, 32'hBFC0_0004);
        wait_ok(0, 20);
        inst_req = 1'b0;
        repeat (2) @(negedge clk);

        // 3: store held against a slow mem_ready
        cfg_ready_wait = 4;
        exp_mem.push_back(mk_mem(32'h8000_2000, 1, 4'h3, 32'h1234_ABCD));
        exp_resp.push_back(mk_resp(1, 32'h1111_2222));
        rd_q.push_back(32'hDEAD_BEEF);
        data_addr = 32'h8000_2000; data_wr = 1; data_wstrb = 4'h3;
        data_wdata = 32'h1234_ABCD;
        data_req = 1'b1;
        hold = 0; done = 0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk); #2;
            if (mem_req) hold++;
            done = data_data_ok;
        end
        chk("t3_ok_seen", 32'(done), 32'd1);
        chk("t3_hold_cycles", 32'(hold), 32'd5);
        data_req = 1'b0;
        cfg_ready_wait = 0;
        repeat (2) @(negedge clk);

        // 3b: store with no strobes is still issued
        exp_mem.push_back(mk_mem(32'h8000_2004, 1, 4'h0, 32'h0000_0000));
        exp_resp.push_back(mk_resp(1, 32'h1111_2222));
        rd_q.push_back(32'hCAFE_F00D);
        data_addr = 32'h8000_2004; data_wstrb = 4'h0; data_wdata = 0;
        data_req = 1'b1;
        wait_ok(1, 20);
        data_req = 1'b0;
        chk("t3_no_timeout", 32'(mem_timeout), 32'd0);
        repeat (2) @(negedge clk);

        // 4: no response, forced completion after 8 WAIT cycles
        cfg_no_rv = 1;
        exp_mem.push_back(mk_mem(32'h8000_3000, 0, 4'h0, 0));
        exp_resp.push_back(mk_resp(1, 32'h0));
        data_addr = 32'h8000_3000; data_wr = 0;
        data_req = 1'b1;
        wait_mem_req(20);
        cnt = 0; done = 0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk); #2;
            cnt++;
            done = data_data_ok;
        end
        chk("t4_ok_cycles", 32'(cnt), 32'd9);
        chk("t4_timeout", 32'(mem_timeout), 32'd1);
        data_req = 1'b0;
        cfg_no_rv = 0;
        exp_mem.push_back(mk_mem(32'hBFC0_0008, 0, 4'h0, 0));
        exp_resp.push_back(mk_resp(0, 32'h0BAD_F00D));
        rd_q.push_back(32'h0BAD_F00D);
        inst_addr = 32'hBFC0_0008;
        inst_req = 1'b1;
        wait_ok(0, 20);
        inst_req = 1'b0;
        chk("t4_timeout_sticky", 32'(mem_timeout), 32'd1);
        repeat (2) @(negedge clk);

        // 5: reset during WAIT, late response ignored
        cfg_rv_wait = 6;
        exp_mem.push_back(mk_mem(32'h8000_4000, 0, 4'h0, 0));
        rd_q.push_back(32'h7777_8888);
        data_addr = 32'h8000_4000;
        data_req = 1'b1;
        wait_mem_req(20);
        @(negedge clk);
        resetn = 1'b0;
        data_req = 1'b0;
        #1;
        chk("t5_rst_mem_req", 32'(mem_req), 32'd0);
        chk("t5_rst_addr", mem_addr, 32'd0);
        chk("t5_rst_rdata", inst_rdata | data_rdata, 32'd0);
        chk("t5_rst_timeout", 32'(mem_timeout), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        chk("t5_late_rvalid_rdata", data_rdata, 32'd0);
        chk("t5_late_rvalid_req", 32'(mem_req), 32'd0);
        cfg_rv_wait = 0;

        // 6: round-robin alternation with both requests held
        rr_q.push_back(0); rr_q.push_back(1);
        rr_q.push_back(0); rr_q.push_back(1);
        rr_inst_req = 1'b1; rr_data_req = 1'b1;
        cnt = 0;
        for (int n = 0; n < 60 && cnt < 4; n++) begin
            @(negedge clk); #2;
            if (rr_inst_ok || rr_data_ok) cnt++;
        end
        rr_inst_req = 1'b0; rr_data_req = 1'b0;
        chk("t6_grants", 32'(cnt), 32'd4);
        repeat (4) @(negedge clk);

        chk("rr_queue_left", 32'(rr_q.size()), 32'd0);
        chk("mem_queue_left", 32'(exp_mem.size()), 32'd0);
        chk("resp_queue_left", 32'(exp_resp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
